// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU control codes and R-type funct codes for the ID/EX stage and the ALU.
// Latency: n/a (types, constants and a combinational forwarding helper only).
// Backpressure: n/a.
package id_ex_stage_pkg;

    localparam int DATA_W        = 32;
    localparam int ALU_CNTL_OP_W = 6;
    localparam int REG_ADDR_W    = 5;

    localparam logic [ALU_CNTL_OP_W-1:0] ALU_AND = 6'h00;
    localparam logic [ALU_CNTL_OP_W-1:0] ALU_OR  = 6'h01;
    localparam logic [ALU_CNTL_OP_W-1:0] ALU_ADD = 6'h02;
    localparam logic [ALU_CNTL_OP_W-1:0] ALU_SUB = 6'h06;
    localparam logic [ALU_CNTL_OP_W-1:0] ALU_SLT = 6'h07;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluOp_e;

    // Everything the ID/EX register holds; an all-zero value is a bubble.
    typedef struct packed {
        logic                     valid;
        logic                     regWrite;
        logic                     memRead;
        logic                     memWrite;
        logic                     branch;
        logic                     memToReg;
        logic                     illegal;
        logic                     aluSrc;
        logic [ALU_CNTL_OP_W-1:0] op;
        logic [REG_ADDR_W-1:0]    writeReg;
        logic [REG_ADDR_W-1:0]    rsAddr;
        logic [REG_ADDR_W-1:0]    rtAddr;
        logic [DATA_W-1:0]        rsData;
        logic [DATA_W-1:0]        rtData;
        logic [DATA_W-1:0]        imm;
    } idExReg_t;

    // Youngest producer wins; r0 is hard-wired and never forwarded.
    function automatic logic [DATA_W-1:0] fwdPick(
        input logic [REG_ADDR_W-1:0] src,
        input logic [DATA_W-1:0]     stored,
        input logic                  exMemWr,
        input logic [REG_ADDR_W-1:0] exMemRd,
        input logic [DATA_W-1:0]     exMemRes,
        input logic                  memWbWr,
        input logic [REG_ADDR_W-1:0] memWbRd,
        input logic [DATA_W-1:0]     memWbRes
    );
        if (exMemWr && (exMemRd != '0) && (exMemRd == src)) return exMemRes;
        if (memWbWr && (memWbRd != '0) && (memWbRd == src)) return memWbRes;
        return stored;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side, forwarding-side and ALU-side signal bundle of the ID/EX stage.
// Latency: n/a (wires only).
// Backpressure: iStall/iFlush in, oLoadUseStall out; no valid/ready pairs.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic                     iValid;
    logic                     iStall;
    logic                     iFlush;
    logic [DATA_W-1:0]        iRsData;
    logic [DATA_W-1:0]        iRtData;
    logic [DATA_W-1:0]        iImm;
    logic [REG_ADDR_W-1:0]    iRsAddr;
    logic [REG_ADDR_W-1:0]    iRtAddr;
    logic [REG_ADDR_W-1:0]    iRdAddr;
    logic [1:0]               iALUOp;
    logic [5:0]               iFunct;
    logic                     iALUSrc;
    logic                     iRegDst;
    logic                     iRegWrite;
    logic                     iMemRead;
    logic                     iMemWrite;
    logic                     iBranch;
    logic                     iMemToReg;
    logic                     iExMemRegWrite;
    logic [REG_ADDR_W-1:0]    iExMemRd;
    logic [DATA_W-1:0]        iExMemResult;
    logic                     iMemWbRegWrite;
    logic [REG_ADDR_W-1:0]    iMemWbRd;
    logic [DATA_W-1:0]        iMemWbResult;

    logic [DATA_W-1:0]        oA;
    logic [DATA_W-1:0]        oB;
    logic [ALU_CNTL_OP_W-1:0] oOp;
    logic [DATA_W-1:0]        oStoreData;
    logic [REG_ADDR_W-1:0]    oWriteReg;
    logic                     oValid;
    logic                     oRegWrite;
    logic                     oMemRead;
    logic                     oMemWrite;
    logic                     oBranch;
    logic                     oMemToReg;
    logic                     oIllegal;
    logic                     oLoadUseStall;

    modport master (
        output iValid, iStall, iFlush, iRsData, iRtData, iImm, iRsAddr, iRtAddr, iRdAddr,
               iALUOp, iFunct, iALUSrc, iRegDst, iRegWrite, iMemRead, iMemWrite, iBranch,
               iMemToReg, iExMemRegWrite, iExMemRd, iExMemResult, iMemWbRegWrite, iMemWbRd,
               iMemWbResult,
        input  oA, oB, oOp, oStoreData, oWriteReg, oValid, oRegWrite, oMemRead, oMemWrite,
               oBranch, oMemToReg, oIllegal, oLoadUseStall
    );

    modport slave (
        input  iValid, iStall, iFlush, iRsData, iRtData, iImm, iRsAddr, iRtAddr, iRdAddr,
               iALUOp, iFunct, iALUSrc, iRegDst, iRegWrite, iMemRead, iMemWrite, iBranch,
               iMemToReg, iExMemRegWrite, iExMemRd, iExMemResult, iMemWbRegWrite, iMemWbRd,
               iMemWbResult,
        output oA, oB, oOp, oStoreData, oWriteReg, oValid, oRegWrite, oMemRead, oMemWrite,
               oBranch, oMemToReg, oIllegal, oLoadUseStall
    );
endinterface

// File: rtl/id_ex_stage_alu_control.sv
// Main ALUOp + funct to ALU control op decode; flags unsupported encodings.
// Latency: combinational.
// Backpressure: none.
module alu_control
    import id_ex_stage_pkg::*;
(
    input  logic [1:0]               aluOp,
    input  logic [5:0]               funct,
    output logic [ALU_CNTL_OP_W-1:0] op,
    output logic                     illegal
);

    always_comb begin
        op      = ALU_AND;
        illegal = 1'b0;
        case (aluOp_e'(aluOp))
            ALUOP_ADD: op = ALU_ADD;
            ALUOP_SUB: op = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: op = ALU_ADD;
                    FUNCT_SUB: op = ALU_SUB;
                    FUNCT_AND: op = ALU_AND;
                    FUNCT_OR:  op = ALU_OR;
                    FUNCT_SLT: op = ALU_SLT;
                    default:   illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register + operand select (forwarding and load-use detection under `IDEX_FORWARD_EN).
// Latency: 1 cycle decode->registered fields; oA/oB/oOp/oStoreData combinational from them.
// Backpressure: iStall holds, iFlush or load-use loads a bubble; oLoadUseStall stalls IF/ID.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    id_ex_stage_if.slave bus
);

    idExReg_t                 stage;
    idExReg_t                 nxt;
    logic [ALU_CNTL_OP_W-1:0] decOp;
    logic                     decIllegal;
    logic                     loadUseStall;
    logic [DATA_W-1:0]        rsFwd;
    logic [DATA_W-1:0]        rtFwd;

    alu_control uAluControl (
        .aluOp   (bus.iALUOp),
        .funct   (bus.iFunct),
        .op      (decOp),
        .illegal (decIllegal)
    );

    // Control bits are qualified by iValid so an empty decode slot enters as a bubble.
    always_comb begin
        nxt          = '0;
        nxt.valid    = bus.iValid;
        nxt.illegal  = bus.iValid && decIllegal;
        nxt.regWrite = bus.iValid && bus.iRegWrite && !decIllegal;
        nxt.memWrite = bus.iValid && bus.iMemWrite && !decIllegal;
        nxt.memRead  = bus.iValid && bus.iMemRead;
        nxt.branch   = bus.iValid && bus.iBranch;
        nxt.memToReg = bus.iValid && bus.iMemToReg;
        nxt.aluSrc   = bus.iALUSrc;
        nxt.op       = decOp;
        nxt.writeReg = bus.iRegDst ? bus.iRdAddr : bus.iRtAddr;
        nxt.rsAddr   = bus.iRsAddr;
        nxt.rtAddr   = bus.iRtAddr;
        nxt.rsData   = bus.iRsData;
        nxt.rtData   = bus.iRtData;
        nxt.imm      = bus.iImm;
    end

    always_ff @(posedge clk) begin
        if (!resetn || bus.iFlush) begin
            stage <= '0;
        end else if (!bus.iStall) begin
            stage <= loadUseStall ? '0 : nxt;
        end
    end

`ifdef IDEX_FORWARD_EN
    assign rsFwd = stage.valid
                 ? fwdPick(stage.rsAddr, stage.rsData, bus.iExMemRegWrite, bus.iExMemRd,
                           bus.iExMemResult, bus.iMemWbRegWrite, bus.iMemWbRd, bus.iMemWbResult)
                 : stage.rsData;
    assign rtFwd = stage.valid
                 ? fwdPick(stage.rtAddr, stage.rtData, bus.iExMemRegWrite, bus.iExMemRd,
                           bus.iExMemResult, bus.iMemWbRegWrite, bus.iMemWbRd, bus.iMemWbResult)
                 : stage.rtData;
    assign loadUseStall = stage.valid && stage.memRead && (stage.writeReg != '0) &&
                          ((stage.writeReg == bus.iRsAddr) || (stage.writeReg == bus.iRtAddr)) &&
                          bus.iValid;
`else
    logic unusedFwd;
    // Without forwarding the scheduler guarantees no hazards, so these inputs are dead.
    assign unusedFwd    = ^{bus.iExMemRegWrite, bus.iExMemRd, bus.iExMemResult,
                            bus.iMemWbRegWrite, bus.iMemWbRd, bus.iMemWbResult,
                            stage.rsAddr, stage.rtAddr};
    assign rsFwd        = stage.rsData;
    assign rtFwd        = stage.rtData;
    assign loadUseStall = 1'b0;
`endif

    assign bus.oA            = rsFwd;
    assign bus.oB            = stage.aluSrc ? stage.imm : rtFwd;
    assign bus.oStoreData    = rtFwd;
    assign bus.oOp           = stage.op;
    assign bus.oWriteReg     = stage.writeReg;
    assign bus.oValid        = stage.valid;
    assign bus.oRegWrite     = stage.regWrite;
    assign bus.oMemRead      = stage.memRead;
    assign bus.oMemWrite     = stage.memWrite;
    assign bus.oBranch       = stage.branch;
    assign bus.oMemToReg     = stage.memToReg;
    assign bus.oIllegal      = stage.illegal;
    assign bus.oLoadUseStall = loadUseStall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed plan items then random traffic vs a
// transaction-level model of what the stage holds.
module tb_id_ex_stage;

    logic clk;
    logic resetn;
    id_ex_stage_if bus ();

    id_ex_stage dut (.clk(clk), .resetn(resetn), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The instruction the model believes sits in the stage (raw decode fields).
    typedef struct packed {
        logic        loaded;
        logic        valid;
        logic [4:0]  rsAddr, rtAddr, rdAddr;
        logic [31:0] rsData, rtData, imm;
        logic [1:0]  aluOp;
        logic [5:0]  funct;
        logic        aluSrc, regDst, regWrite, memRead, memWrite, branch, memToReg;
    } slot_t;

    typedef struct packed {
        logic [31:0] a, b, store;
        logic [5:0]  op;
        logic [4:0]  wr;
        logic        valid, regWrite, memRead, memWrite, branch, memToReg, illegal, stall;
    } exp_t;

    exp_t  expQ [$];
    slot_t m;
    int    checks = 0;
    int    passed = 0;
    logic [5:0] functPick [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h21, 6'h00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Returns {legal, op}.
    function automatic logic [6:0] aluRef(input logic [1:0] aluOp, input logic [5:0] funct);
        logic [5:0] fTab [5];
        logic [5:0] oTab [5];
        fTab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        oTab = '{6'h02, 6'h06, 6'h00, 6'h01, 6'h07};
        if (aluOp == 2'd0) return {1'b1, 6'h02};
        if (aluOp == 2'd1) return {1'b1, 6'h06};
        if (aluOp == 2'd2)
            for (int k = 0; k < 5; k++) if (fTab[k] == funct) return {1'b1, oTab[k]};
        return {1'b0, 6'h00};
    endfunction

    function automatic logic [31:0] fwdRef(input logic [4:0] src, input logic [31:0] stored);
        if (src == 5'd0) return stored;
        if (bus.iExMemRegWrite && bus.iExMemRd == src) return bus.iExMemResult;
        if (bus.iMemWbRegWrite && bus.iMemWbRd == src) return bus.iMemWbResult;
        return stored;
    endfunction

    function automatic exp_t predict(input slot_t e);
        exp_t x;
        logic [6:0] dec;
        logic [31:0] rsV, rtV;
        x = '0;
        if (!e.loaded) return x;
        dec = aluRef(e.aluOp, e.funct);
        rsV = e.rsData;
        rtV = e.rtData;
`ifdef IDEX_FORWARD_EN
        if (e.valid) begin
            rsV = fwdRef(e.rsAddr, e.rsData);
            rtV = fwdRef(e.rtAddr, e.rtData);
        end
`endif
        x.a        = rsV;
        x.store    = rtV;
        x.b        = e.aluSrc ? e.imm : rtV;
        x.op       = dec[5:0];
        x.wr       = e.regDst ? e.rdAddr : e.rtAddr;
        x.valid    = e.valid;
        x.illegal  = e.valid && !dec[6];
        x.regWrite = e.valid && e.regWrite && dec[6];
        x.memWrite = e.valid && e.memWrite && dec[6];
        x.memRead  = e.valid && e.memRead;
        x.branch   = e.valid && e.branch;
        x.memToReg = e.valid && e.memToReg;
`ifdef IDEX_FORWARD_EN
        x.stall = x.memRead && x.wr != 5'd0 && bus.iValid &&
                  (x.wr == bus.iRsAddr || x.wr == bus.iRtAddr);
`endif
        return x;
    endfunction

    function automatic slot_t capture();
        slot_t s;
        s.loaded = 1'b1;         s.valid = bus.iValid;
        s.rsAddr = bus.iRsAddr;  s.rtAddr = bus.iRtAddr;  s.rdAddr = bus.iRdAddr;
        s.rsData = bus.iRsData;  s.rtData = bus.iRtData;  s.imm = bus.iImm;
        s.aluOp  = bus.iALUOp;   s.funct = bus.iFunct;
        s.aluSrc = bus.iALUSrc;  s.regDst = bus.iRegDst;  s.regWrite = bus.iRegWrite;
        s.memRead = bus.iMemRead; s.memWrite = bus.iMemWrite;
        s.branch = bus.iBranch;  s.memToReg = bus.iMemToReg;
        return s;
    endfunction

    // Predict this cycle's outputs, then advance the model across the coming edge.
    task automatic step();
        exp_t  x;
        slot_t nx;
        x = predict(m);
        expQ.push_back(x);
        nx = m;
        if (!resetn || bus.iFlush) nx = '0;
        else if (!bus.iStall) nx = x.stall ? slot_t'('0) : capture();
        @(posedge clk);
        #1;
        m = nx;
    endtask

    task automatic idle();
        resetn = 1'b1;
        bus.iValid = 0; bus.iStall = 0; bus.iFlush = 0;
        bus.iRsData = 0; bus.iRtData = 0; bus.iImm = 0;
        bus.iRsAddr = 0; bus.iRtAddr = 0; bus.iRdAddr = 0;
        bus.iALUOp = 0; bus.iFunct = 0; bus.iALUSrc = 0; bus.iRegDst = 0;
        bus.iRegWrite = 0; bus.iMemRead = 0; bus.iMemWrite = 0; bus.iBranch = 0; bus.iMemToReg = 0;
        bus.iExMemRegWrite = 0; bus.iExMemRd = 0; bus.iExMemResult = 0;
        bus.iMemWbRegWrite = 0; bus.iMemWbRd = 0; bus.iMemWbResult = 0;
    endtask

    task automatic instr(input logic [1:0] aluOp, input logic [5:0] funct,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsD, input logic [31:0] rtD, input logic [31:0] imm,
                         input logic aluSrc, input logic regDst, input logic regWr,
                         input logic memRd, input logic memWr);
        bus.iValid = 1; bus.iALUOp = aluOp; bus.iFunct = funct;
        bus.iRsAddr = rs; bus.iRtAddr = rt; bus.iRdAddr = rd;
        bus.iRsData = rsD; bus.iRtData = rtD; bus.iImm = imm;
        bus.iALUSrc = aluSrc; bus.iRegDst = regDst; bus.iRegWrite = regWr;
        bus.iMemRead = memRd; bus.iMemWrite = memWr; bus.iMemToReg = memRd; bus.iBranch = 0;
    endtask

    task automatic randIn();
        resetn = ($urandom_range(0, 99) != 0);
        bus.iValid = ($urandom_range(0, 9) != 0);
        bus.iStall = ($urandom_range(0, 7) == 0);
        bus.iFlush = ($urandom_range(0, 15) == 0);
        bus.iRsData = $urandom; bus.iRtData = $urandom; bus.iImm = $urandom;
        bus.iRsAddr = 5'($urandom_range(0, 7));
        bus.iRtAddr = 5'($urandom_range(0, 7));
        bus.iRdAddr = 5'($urandom_range(0, 7));
        bus.iALUOp = 2'($urandom_range(0, 3));
        bus.iFunct = functPick[$urandom_range(0, 7)];
        bus.iALUSrc = 1'($urandom); bus.iRegDst = 1'($urandom);
        bus.iRegWrite = 1'($urandom); bus.iMemRead = ($urandom_range(0, 2) == 0);
        bus.iMemWrite = 1'($urandom); bus.iBranch = 1'($urandom); bus.iMemToReg = 1'($urandom);
        bus.iExMemRegWrite = 1'($urandom); bus.iExMemRd = 5'($urandom_range(0, 7));
        bus.iExMemResult = $urandom;
        bus.iMemWbRegWrite = 1'($urandom); bus.iMemWbRd = 5'($urandom_range(0, 7));
        bus.iMemWbResult = $urandom;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                x = expQ.pop_front();
                chk("oA",            bus.oA,                    x.a);
                chk("oB",            bus.oB,                    x.b);
                chk("oStoreData",    bus.oStoreData,            x.store);
                chk("oOp",           32'(bus.oOp),              32'(x.op));
                chk("oWriteReg",     32'(bus.oWriteReg),        32'(x.wr));
                chk("oValid",        32'(bus.oValid),           32'(x.valid));
                chk("oRegWrite",     32'(bus.oRegWrite),        32'(x.regWrite));
                chk("oMemRead",      32'(bus.oMemRead),         32'(x.memRead));
                chk("oMemWrite",     32'(bus.oMemWrite),        32'(x.memWrite));
                chk("oBranch",       32'(bus.oBranch),          32'(x.branch));
                chk("oMemToReg",     32'(bus.oMemToReg),        32'(x.memToReg));
                chk("oIllegal",      32'(bus.oIllegal),         32'(x.illegal));
                chk("oLoadUseStall", 32'(bus.oLoadUseStall),    32'(x.stall));
            end
        end
    end

    initial begin
        m = '0;
        // Reset held with random inputs: outputs must stay cleared.
        randIn(); resetn = 0;
        @(posedge clk); #1;
        randIn(); resetn = 0; step();
        randIn(); resetn = 0; step();

        // First add, then decode variants.
        idle(); instr(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 0, 1, 1, 0, 0); step();
        idle(); instr(2'd2, 6'h2A, 5'd1, 5'd2, 5'd3, 32'd3, 32'd9, 32'd0, 0, 1, 1, 0, 0); step();
        idle(); instr(2'd1, 6'h00, 5'd1, 5'd2, 5'd0, 32'd8, 32'd8, 32'd0, 0, 0, 0, 0, 0); step();
        idle(); instr(2'd2, 6'h08, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 0, 1, 1, 0, 1); step();

        // Forwarding priority while the stage is held for three cycles.
        idle(); instr(2'd0, 6'h00, 5'd4, 5'd5, 5'd0, 32'd1, 32'd2, 32'd0, 0, 0, 1, 0, 0); step();
        idle(); bus.iStall = 1;
        bus.iExMemRegWrite = 1; bus.iExMemRd = 5'd4; bus.iExMemResult = 32'h55;
        bus.iMemWbRegWrite = 1; bus.iMemWbRd = 5'd4; bus.iMemWbResult = 32'h66; step();
        bus.iExMemRegWrite = 0; step();
        bus.iMemWbRegWrite = 0; step();
        idle(); instr(2'd0, 6'h00, 5'd0, 5'd0, 5'd0, 32'h123, 32'h0, 32'd0, 0, 0, 0, 0, 0); step();
        idle(); bus.iExMemRegWrite = 1; bus.iExMemRd = 5'd0; bus.iExMemResult = 32'hAA;
        bus.iMemWbRegWrite = 1; bus.iMemWbRd = 5'd0; bus.iMemWbResult = 32'hBB; step();

        // Load-use: lw r8 then a consumer of r8.
        idle(); instr(2'd0, 6'h00, 5'd1, 5'd8, 5'd0, 32'h100, 32'd0, 32'd4, 1, 0, 1, 1, 0); step();
        idle(); instr(2'd2, 6'h20, 5'd8, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 0, 1, 1, 0, 0); step();
        step(); step();

        // Stall and flush together: flush wins.
        idle(); bus.iStall = 1; bus.iFlush = 1; step();
        idle(); step();

        // ALUSrc with forwarded store data.
        idle(); instr(2'd0, 6'h00, 5'd1, 5'd6, 5'd0, 32'd0, 32'd7, 32'hFFFF_FFFC, 1, 0, 0, 0, 1); step();
        idle(); bus.iExMemRegWrite = 1; bus.iExMemRd = 5'd6; bus.iExMemResult = 32'h10; step();
        idle(); step();

        for (int i = 0; i < 3000; i++) begin
            randIn();
            step();
        end

        idle();
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
